// File: rtl/ucode_loader_if.sv
// Byte-stream input and uCode memory write / run-control bundle for ucode_loader.
// master is the loader side; slave is the receiver/CPU side.
interface ucode_loader_if #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 10
);
  logic               i_rx_wr;
  logic [7:0]         i_rx_data;
  logic               o_wr;
  logic [ADDR_SZ-1:0] o_waddr;
  logic [DATA_SZ-1:0] o_wdata;
  logic               o_run;
  logic               o_busy;
  logic [1:0]         o_err;

  modport master (
    input  i_rx_wr, i_rx_data,
    output o_wr, o_waddr, o_wdata, o_run, o_busy, o_err
  );

  modport slave (
    output i_rx_wr, i_rx_data,
    input  o_wr, o_waddr, o_wdata, o_run, o_busy, o_err
  );
endinterface

// File: rtl/ucode_loader.sv
// Serial boot loader: decodes framed load/run commands from a byte stream,
// streams words into uCode program memory and gates the CPU run signal.
module ucode_loader #(
  parameter int         DATA_SZ = 16,
  parameter int         ADDR_SZ = 10,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 48_000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ucode_loader_if.master bus
);

  localparam int MEM_MAX = 1 << ADDR_SZ;
  localparam int TW      = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_RUN
  } state_t;

  state_t        state;
  logic [15:0]   addr;
  logic [15:0]   cnt;
  logic [7:0]    sum;
  logic [TW-1:0] timer;
  logic [7:0]    data_hi;
  logic          zero_cnt;

  logic [7:0]    sum_nxt;
  logic [15:0]   cnt_full;
  logic [16:0]   end_addr;
  logic          range_bad;

  assign sum_nxt   = sum + bus.i_rx_data;
  assign cnt_full  = {cnt[15:8], bus.i_rx_data};
  assign end_addr  = {1'b0, addr} + {1'b0, cnt_full};
  // The whole block must fit below MEM_MAX; a block ending exactly at MEM_MAX is legal.
  assign range_bad = ((addr >> ADDR_SZ) != 16'd0) || (end_addr > 17'(MEM_MAX));

  assign bus.o_busy = (state != S_IDLE) && (state != S_RUN);

  // NOTE: all state and outputs here are sequential, so only non-blocking
  // assignments are used; blocking ones would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      cnt         <= '0;
      sum         <= '0;
      timer       <= '0;
      data_hi     <= '0;
      zero_cnt    <= 1'b0;
      bus.o_wr    <= 1'b0;
      bus.o_waddr <= '0;
      bus.o_wdata <= '0;
      bus.o_run   <= 1'b0;
      bus.o_err   <= 2'd0;
    end else begin
      bus.o_wr <= 1'b0;
      if (bus.i_rx_wr) begin
        // An accepted byte always wins over a timeout firing on the same cycle.
        timer <= '0;
        unique case (state)
          S_IDLE, S_RUN: begin
            if (bus.i_rx_data == SYNC) begin
              sum       <= '0;
              bus.o_err <= 2'd0;
              bus.o_run <= 1'b0;
              state     <= S_ADDR_HI;
            end
          end
          S_ADDR_HI: begin
            sum         <= sum_nxt;
            addr[15:8]  <= bus.i_rx_data;
            state       <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            sum         <= sum_nxt;
            addr[7:0]   <= bus.i_rx_data;
            state       <= S_CNT_HI;
          end
          S_CNT_HI: begin
            sum         <= sum_nxt;
            cnt[15:8]   <= bus.i_rx_data;
            state       <= S_CNT_LO;
          end
          S_CNT_LO: begin
            sum <= sum_nxt;
            cnt <= cnt_full;
            if (range_bad) begin
              bus.o_err <= 2'd2;
              state     <= S_IDLE;
            end else if (cnt_full == 16'd0) begin
              zero_cnt  <= 1'b1;
              state     <= S_CHECK;
            end else begin
              zero_cnt  <= 1'b0;
              state     <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            sum     <= sum_nxt;
            data_hi <= bus.i_rx_data;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: begin
            sum         <= sum_nxt;
            bus.o_wr    <= 1'b1;
            bus.o_waddr <= addr[ADDR_SZ-1:0];
            bus.o_wdata <= DATA_SZ'({data_hi, bus.i_rx_data});
            addr        <= addr + 16'd1;
            cnt         <= cnt - 16'd1;
            state       <= (cnt == 16'd1) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            sum <= sum_nxt;
            if (sum_nxt != 8'd0) begin
              bus.o_err <= 2'd1;
              state     <= S_IDLE;
            end else if (zero_cnt) begin
              bus.o_run <= 1'b1;
              state     <= S_RUN;
            end else begin
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (bus.o_busy) begin
        if (timer == TW'(TIMEOUT - 1)) begin
          timer     <= '0;
          bus.o_err <= 2'd3;
          state     <= S_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: directed frames, randomized frames
// against a frame-level reference model, timeout and reset behaviour.
module tb_ucode_loader;

  localparam int TIMEOUT = 100;
  localparam int MEM_MAX = 1024;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  ucode_loader_if #(.DATA_SZ(16), .ADDR_SZ(10)) bus ();

  ucode_loader #(
    .DATA_SZ(16),
    .ADDR_SZ(10),
    .SYNC(8'hA5),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  logic [15:0] word_src[$];
  logic        exp_run = 1'b0;

  always @(posedge i_clk) begin
    #1;
    if (bus.o_wr === 1'b1) got_q.push_back({bus.o_waddr, bus.o_wdata});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, " write"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " o_wr"},    bus.o_wr,    0);
    check({tag, " o_waddr"}, bus.o_waddr, 0);
    check({tag, " o_wdata"}, bus.o_wdata, 0);
    check({tag, " o_run"},   bus.o_run,   0);
    check({tag, " o_busy"},  bus.o_busy,  0);
    check({tag, " o_err"},   bus.o_err,   0);
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
    @(negedge i_clk);
    bus.i_rx_data = b;
    bus.i_rx_wr   = 1'b1;
    @(negedge i_clk);
    bus.i_rx_wr   = 1'b0;
  endtask

  // Frame-level model: range rule, streamed writes, checksum rule, run rule.
  task automatic run_frame(input string tag, input int addr, input int cnt, input int chk_off);
    logic [7:0]  sum;
    logic [15:0] w;
    logic [1:0]  exp_err;
    logic        range_ok;
    sum = 8'd0;
    send(8'hA5);
    exp_run = 1'b0;
    check({tag, " run after sync"}, bus.o_run, exp_run);
    check({tag, " busy after sync"}, bus.o_busy, 1);
    send(8'(addr >> 8)); sum += 8'(addr >> 8);
    send(8'(addr));      sum += 8'(addr);
    send(8'(cnt >> 8));  sum += 8'(cnt >> 8);
    send(8'(cnt));       sum += 8'(cnt);
    range_ok = (addr < MEM_MAX) && (addr + cnt <= MEM_MAX);
    if (!range_ok) begin
      check({tag, " range err"}, bus.o_err, 2);
      check({tag, " range busy"}, bus.o_busy, 0);
      check({tag, " range run"}, bus.o_run, 0);
      check_writes(tag);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      w = (word_src.size() != 0) ? word_src.pop_front() : 16'($urandom);
      send(w[15:8]); sum += w[15:8];
      send(w[7:0]);  sum += w[7:0];
      exp_q.push_back({10'(addr + i), w});
    end
    check({tag, " run before chk"}, bus.o_run, 0);
    check({tag, " busy before chk"}, bus.o_busy, 1);
    send(8'(-sum) + 8'(chk_off));
    exp_err = (chk_off % 256 != 0) ? 2'd1 : 2'd0;
    exp_run = (exp_err == 2'd0) && (cnt == 0);
    check({tag, " err"},  bus.o_err,  exp_err);
    check({tag, " run"},  bus.o_run,  exp_run);
    check({tag, " busy"}, bus.o_busy, 0);
    check_writes(tag);
  endtask

  initial begin
    int a, c, off;
    bus.i_rx_wr   = 1'b0;
    bus.i_rx_data = 8'h00;

    repeat (2) @(negedge i_clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check_all_zero("post reset idle");

    // Directed frames from the test plan.
    word_src.push_back(16'h1234);
    word_src.push_back(16'hABCD);
    run_frame("load2", 'h010, 2, 0);
    run_frame("runframe", 0, 0, 0);
    run_frame("reload bad chk", 'h020, 1, 1);
    run_frame("range 3ff+2", 'h3FF, 2, 0);
    run_frame("range 3ff+1", 'h3FF, 1, 0);
    run_frame("range hi bits", 'h0400, 1, 0);
    word_src.push_back(16'hA5A5);
    run_frame("sync as data", 'h100, 1, 0);
    run_frame("full mem edge", 'h3FC, 4, 0);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      a   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1023));
      c   = $urandom_range(0, 4);
      off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
      run_frame("random", a, c, off);
    end

    // Timeout fires exactly TIMEOUT cycles after the last strobe.
    send(8'hA5);
    send(8'h00);
    repeat (TIMEOUT - 1) @(negedge i_clk);
    check("timeout not yet err", bus.o_err, 0);
    check("timeout not yet busy", bus.o_busy, 1);
    @(negedge i_clk);
    check("timeout err", bus.o_err, 3);
    check("timeout busy", bus.o_busy, 0);
    check("timeout run", bus.o_run, 0);

    // A byte landing on the timeout cycle wins and restarts the timer.
    send(8'hA5);
    send(8'h00);
    repeat (TIMEOUT - 1) @(negedge i_clk);
    bus.i_rx_data = 8'h00;
    bus.i_rx_wr   = 1'b1;
    @(negedge i_clk);
    bus.i_rx_wr   = 1'b0;
    check("byte wins err", bus.o_err, 0);
    check("byte wins busy", bus.o_busy, 1);
    repeat (TIMEOUT - 1) @(negedge i_clk);
    check("restart not yet err", bus.o_err, 0);
    @(negedge i_clk);
    check("restart timeout err", bus.o_err, 3);
    check("restart timeout busy", bus.o_busy, 0);

    // Asynchronous reset while running.
    run_frame("run before reset", 0, 0, 0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("reset in run");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Asynchronous reset during a write pulse.
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02); send(8'h12);
    @(negedge i_clk);
    bus.i_rx_data = 8'h34;
    bus.i_rx_wr   = 1'b1;
    @(posedge i_clk);
    #2;
    check("pulse before reset wr", bus.o_wr, 1);
    check("pulse before reset addr", bus.o_waddr, 'h010);
    check("pulse before reset data", bus.o_wdata, 'h1234);
    i_rst_n = 1'b0;
    bus.i_rx_wr = 1'b0;
    #1 check_all_zero("reset mid frame");
    got_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_all_zero("idle after reset");
    check("no stray writes", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
